bsg_fsb_node_responder: RTL and testbench

FSB client node that terminates request packets issued over the front-side bus by a remote master and returns one reply packet per accepted request. It sits on one `nodes_p` slot of the chip-side FSB, alongside or instead of the test node, and is the responder for master-initiated traffic crossing the comm link. It provides echo, scratch-register read/write and request-count services for link bring-up.

---
 rtl/bsg_fsb_node_responder_pkg.sv | 35 +++
 rtl/bsg_fsb_node_responder_two_fifo.sv | 78 +++++++
 rtl/bsg_fsb_node_responder.sv | 125 ++++++++++++
 tb/tb_bsg_fsb_node_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_node_responder_pkg.sv
// Package: bsg_fsb_node_responder_pkg
//
// Shared definitions for the FSB responder node: field widths of the
// 80-bit FSB packet, the opcode encoding understood by the responder and
// a packed struct that overlays the packet layout
//   [79:76] destid, [75] cmd, [74:72] opcode, [71:64] seq, [63:0] payload.

package bsg_fsb_node_responder_pkg;

    localparam int DESTID_W  = 4;
    localparam int OPCODE_W  = 3;
    localparam int SEQ_W     = 8;
    localparam int PAYLOAD_W = 64;
    localparam int CNT_W     = 16;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ECHO  = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_COUNT = 3'd3,
        OP_CSUM  = 3'd4,
        OP_ERR   = 3'd7
    } opcode_e;

    // Opcode is kept as raw bits: requests may carry the unassigned
    // encodings 5 and 6, which must still be decoded (into ERR replies).
    typedef struct packed {
        logic [DESTID_W-1:0]  destid;
        logic                 cmd;
        logic [OPCODE_W-1:0]  opcode;
        logic [SEQ_W-1:0]     seq;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_s;

endpackage

// File: rtl/bsg_fsb_node_responder_two_fifo.sv
// Module: bsg_two_fifo
//
// Two-entry FIFO with a valid-ready input and a valid-yumi output.
// ready_o is a registered "not full" flag, so it never depends
// combinationally on yumi_i, and it is low while in reset.
//
// Ports:
//   clk_i      in   clock
//   reset_n_i  in   asynchronous active-low reset (empties the FIFO)
//   v_i        in   enqueue request (honoured only when ready_o is high)
//   data_i     in   [width_p] enqueue data
//   ready_o    out  space available
//   v_o        out  head entry valid
//   data_o     out  [width_p] head entry
//   yumi_i     in   head consumed (only meaningful while v_o is high)

module bsg_two_fifo #(
    parameter int width_p = 80
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic [1:0]         count_next;
    logic               ready_r;
    logic               enq;
    logic               deq;

    assign enq     = v_i & ready_r;
    assign deq     = yumi_i & v_o;
    assign ready_o = ready_r;
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rd_ptr_r];

    always_comb begin
        // NOTE: the default assignment first means every path drives
        // count_next, so no latch is inferred.
        count_next = count_r;
        case ({enq, deq})
            2'b10:   count_next = count_r + 2'd1;
            2'b01:   count_next = count_r - 2'd1;
            default: count_next = count_r;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            ready_r  <= 1'b0;
        end else begin
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (deq) rd_ptr_r <= ~rd_ptr_r;
            count_r <= count_next;
            ready_r <= (count_next != 2'd2);
        end
    end

    // NOTE: storage is deliberately not reset; count_r alone decides which
    // entries are meaningful, so clearing the data would buy nothing.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_fsb_node_responder.sv
// Module: bsg_fsb_node_responder
//
// FSB client node that answers master-initiated request packets with one
// reply packet each: echo, scratch write/read, request count and an
// optional running XOR checksum. Replies are buffered in a two-entry FIFO
// and leave in acceptance order with one cycle of latency.
//
// Optional feature macro: BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
//   defined   -> 64-bit checksum register, CSUM returns XOR of prior payloads
//   undefined -> no checksum register, CSUM returns payload 0
//
// Ports:
//   clk_i      in   core clock
//   reset_n_i  in   asynchronous active-low reset
//   en_i       in   node enable; when low nothing is accepted or presented
//   v_i        in   request valid
//   data_i     in   [ring_width_p] request packet
//   ready_o    out  request accept (valid-ready)
//   v_o        out  reply valid
//   data_o     out  [ring_width_p] reply packet
//   yumi_i     in   reply consumed (valid-yumi)

module bsg_fsb_node_responder
    import bsg_fsb_node_responder_pkg::*;
#(
    parameter int ring_width_p = 80,
    parameter int master_id_p  = 0,
    parameter int client_id_p  = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    pkt_s                 req;
    pkt_s                 reply;
    logic                 fifo_ready;
    logic                 fifo_v;
    logic                 accept;
    logic                 drop;
    logic                 serve;
    logic [PAYLOAD_W-1:0] scratch_r;
    logic [CNT_W-1:0]     req_cnt_r;
`ifdef BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
    logic [PAYLOAD_W-1:0] checksum_r;
`endif

    assign req     = pkt_s'(data_i);
    assign ready_o = en_i & fifo_ready;
    assign v_o     = en_i & fifo_v;
    assign accept  = v_i & ready_o;

    // Foreign-destination and command packets are consumed silently.
    assign drop  = (req.destid != DESTID_W'(client_id_p)) | req.cmd;
    assign serve = accept & ~drop;

    // Reply is formed from the state as it stands before this request's
    // updates, which gives COUNT/CSUM their "prior requests" meaning.
    always_comb begin
        reply.destid  = DESTID_W'(master_id_p);
        reply.cmd     = 1'b0;
        reply.opcode  = req.opcode;
        reply.seq     = req.seq;
        reply.payload = req.payload;
        case (req.opcode)
            OP_ECHO,
            OP_WRITE: reply.payload = req.payload;
            OP_READ:  reply.payload = scratch_r;
            OP_COUNT: reply.payload = PAYLOAD_W'(req_cnt_r);
            OP_CSUM: begin
`ifdef BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
                reply.payload = checksum_r;
`else
                reply.payload = '0;
`endif
            end
            default: begin
                reply.opcode  = OP_ERR;
                reply.payload = PAYLOAD_W'(req.opcode);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scratch_r <= '0;
            req_cnt_r <= '0;
        end else if (serve) begin
            if (req.opcode == OP_WRITE) scratch_r <= req.payload;
            req_cnt_r <= req_cnt_r + CNT_W'(1);
        end
    end

`ifdef BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            checksum_r <= '0;
        end else if (serve) begin
            checksum_r <= checksum_r ^ req.payload;
        end
    end
`endif

    // Consumption is qualified with the gated v_o so a stray yumi while
    // disabled cannot pop a retained reply.
    bsg_two_fifo #(
        .width_p (ring_width_p)
    ) reply_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (serve),
        .data_i    (ring_width_p'(reply)),
        .ready_o   (fifo_ready),
        .v_o       (fifo_v),
        .data_o    (data_o),
        .yumi_i    (yumi_i & v_o)
    );

endmodule

// File: tb/tb_bsg_fsb_node_responder.sv
// Testbench: tb_bsg_fsb_node_responder
//
// Directed stimulus against a transaction-level model (reply queue plus
// scratch/count/checksum variables). A compare process checks ready_o,
// v_o and data_o on every falling edge; literal expectations on the
// collected replies pin the model to hand-computed values.

module tb_bsg_fsb_node_responder;

    localparam int RW        = 80;
    localparam int MASTER_ID = 2;
    localparam int CLIENT_ID = 0;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          en_i    = 1'b0;
    logic          v_i     = 1'b0;
    logic          yumi_i  = 1'b0;
    logic [RW-1:0] data_i  = '0;
    logic          ready_o;
    logic          v_o;
    logic [RW-1:0] data_o;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [RW-1:0] mq[$];
    logic [RW-1:0] got[$];
    logic [63:0]   m_scratch = '0;
    logic [63:0]   m_csum    = '0;
    logic [15:0]   m_cnt     = '0;
    bit            alive     = 1'b0;
    bit            m_rdy;
    bit            m_pop;
    bit            m_push;
    logic [RW-1:0] m_reply;
    int            base;

    bsg_fsb_node_responder #(
        .ring_width_p (RW),
        .master_id_p  (MASTER_ID),
        .client_id_p  (CLIENT_ID)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .en_i      (en_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pk(input logic [3:0] d, input logic c, input logic [2:0] op,
                                         input logic [7:0] seq, input logic [63:0] pl);
        return {d, c, op, seq, pl};
    endfunction

    // Reply rules, straight from the opcode table.
    function automatic logic [RW-1:0] model_reply(input logic [RW-1:0] req);
        logic [2:0]  op;
        logic [2:0]  rop;
        logic [63:0] pl;
        op  = req[74:72];
        rop = op;
        pl  = req[63:0];
        case (op)
            3'd0, 3'd1: pl = req[63:0];
            3'd2:       pl = m_scratch;
            3'd3:       pl = {48'b0, m_cnt};
            3'd4: begin
`ifdef BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
                pl = m_csum;
`else
                pl = 64'd0;
`endif
            end
            default: begin
                rop = 3'd7;
                pl  = {61'b0, op};
            end
        endcase
        return pk(4'(MASTER_ID), 1'b0, rop, req[71:64], pl);
    endfunction

    // Model update on each rising edge (inputs are stable there).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_scratch = '0;
            m_cnt     = '0;
            m_csum    = '0;
            alive     = 1'b0;
        end else begin
            m_rdy  = alive && en_i && (mq.size() < 2);
            m_pop  = en_i && (mq.size() > 0) && yumi_i;
            m_push = m_rdy && v_i && (data_i[79:76] == 4'(CLIENT_ID)) && !data_i[75];
            if (m_push) begin
                m_reply = model_reply(data_i);
                if (data_i[74:72] == 3'd1) m_scratch = data_i[63:0];
                m_cnt = m_cnt + 16'd1;
`ifdef BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
                m_csum = m_csum ^ data_i[63:0];
`endif
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(m_reply);
            alive = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check_bit("ready_o", ready_o, alive && en_i && (mq.size() < 2));
            check_bit("v_o", v_o, en_i && (mq.size() > 0));
            if (v_o && en_i && (mq.size() > 0)) check("data_o", data_o, mq[0]);
            if (v_o && yumi_i) got.push_back(data_o);
        end
    end

    task automatic check_got(input string name, input int idx, input logic [RW-1:0] exp);
        logic [RW-1:0] act;
        act = 'x;
        if (idx < got.size()) act = got[idx];
        check(name, act, exp);
    endtask

    // Called just after a rising edge; returns just after the edge that
    // accepted the request.
    task automatic send(input logic [RW-1:0] p);
        bit acc;
        acc    = 1'b0;
        v_i    = 1'b1;
        data_i = p;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #2;
        end
        v_i = 1'b0;
        if (!acc) check_bit("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        en_i   = 1'b1;
        yumi_i = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check_bit("rst_ready", ready_o, 1'b0);
        check_bit("rst_v", v_o, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // READ after reset, then ECHO with next-cycle latency
        base = got.size();
        send(pk(4'd0, 1'b0, 3'd2, 8'h01, 64'd0));
        send(pk(4'd0, 1'b0, 3'd0, 8'h11, 64'hDEADBEEF));
        @(negedge clk);
        check_bit("echo_latency_v", v_o, 1'b1);
        check("echo_latency_data", data_o, pk(4'd2, 1'b0, 3'd0, 8'h11, 64'hDEADBEEF));
        idle(3);
        check_got("read_initial", base, pk(4'd2, 1'b0, 3'd2, 8'h01, 64'd0));
        check_got("echo", base + 1, pk(4'd2, 1'b0, 3'd0, 8'h11, 64'hDEADBEEF));

        // WRITE then READ back-to-back
        base = got.size();
        send(pk(4'd0, 1'b0, 3'd1, 8'h02, 64'h1234));
        send(pk(4'd0, 1'b0, 3'd2, 8'h03, 64'h0));
        idle(3);
        check_got("write_reply", base, pk(4'd2, 1'b0, 3'd1, 8'h02, 64'h1234));
        check_got("read_after_write", base + 1, pk(4'd2, 1'b0, 3'd2, 8'h03, 64'h1234));

        // Backpressure: two fill the FIFO, third waits for a yumi pulse
        yumi_i = 1'b0;
        base   = got.size();
        send(pk(4'd0, 1'b0, 3'd0, 8'h21, 64'hA1));
        send(pk(4'd0, 1'b0, 3'd0, 8'h22, 64'hA2));
        fork
            send(pk(4'd0, 1'b0, 3'd0, 8'h23, 64'hA3));
            begin
                @(negedge clk);
                check_bit("bp_ready_low", ready_o, 1'b0);
                check_bit("bp_v_high", v_o, 1'b1);
                idle(2);
                yumi_i = 1'b1;
                idle(1);
                yumi_i = 1'b0;
            end
        join
        yumi_i = 1'b1;
        idle(4);
        check_int("bp_reply_count", got.size(), base + 3);
        check_got("bp_first", base, pk(4'd2, 1'b0, 3'd0, 8'h21, 64'hA1));
        check_got("bp_second", base + 1, pk(4'd2, 1'b0, 3'd0, 8'h22, 64'hA2));
        check_got("bp_third", base + 2, pk(4'd2, 1'b0, 3'd0, 8'h23, 64'hA3));

        // Request counter wrap, then dropped requests leave it unchanged
        do_reset();
        for (int i = 0; i < 65536; i++) send(pk(4'd0, 1'b0, 3'd0, 8'(i), 64'(i)));
        idle(3);
        base = got.size();
        send(pk(4'd0, 1'b0, 3'd3, 8'h31, 64'd0));
        send(pk(4'd5, 1'b0, 3'd0, 8'h32, 64'hBAD));
        send(pk(4'd0, 1'b1, 3'd1, 8'h33, 64'hBAD));
        send(pk(4'd0, 1'b0, 3'd3, 8'h34, 64'd0));
        idle(3);
        check_int("drop_no_reply", got.size(), base + 2);
        check_got("count_wrap", base, pk(4'd2, 1'b0, 3'd3, 8'h31, 64'd0));
        check_got("count_after_drop", base + 1, pk(4'd2, 1'b0, 3'd3, 8'h34, 64'd1));

        // Unassigned opcode and READ proving the dropped WRITE was ignored
        base = got.size();
        send(pk(4'd0, 1'b0, 3'd6, 8'h41, 64'h123));
        send(pk(4'd0, 1'b0, 3'd2, 8'h42, 64'd0));
        idle(3);
        check_got("err_op6", base, pk(4'd2, 1'b0, 3'd7, 8'h41, 64'd6));
        check_got("drop_kept_scratch", base + 1, pk(4'd2, 1'b0, 3'd2, 8'h42, 64'd0));

        // Checksum
        do_reset();
        base = got.size();
        send(pk(4'd0, 1'b0, 3'd0, 8'h51, 64'hF0));
        send(pk(4'd0, 1'b0, 3'd0, 8'h52, 64'h0F));
        send(pk(4'd0, 1'b0, 3'd4, 8'h53, 64'd0));
        idle(3);
`ifdef BSG_FSB_NODE_RESPONDER_CHECKSUM_EN
        check_got("csum", base + 2, pk(4'd2, 1'b0, 3'd4, 8'h53, 64'hFF));
`else
        check_got("csum", base + 2, pk(4'd2, 1'b0, 3'd4, 8'h53, 64'h0));
`endif

        // Enable gating retains the buffered reply
        yumi_i = 1'b0;
        base   = got.size();
        send(pk(4'd0, 1'b0, 3'd0, 8'h61, 64'h55));
        en_i = 1'b0;
        @(negedge clk);
        check_bit("en_off_v", v_o, 1'b0);
        check_bit("en_off_ready", ready_o, 1'b0);
        v_i    = 1'b1;
        data_i = pk(4'd0, 1'b0, 3'd0, 8'h62, 64'h66);
        idle(2);
        v_i  = 1'b0;
        en_i = 1'b1;
        @(negedge clk);
        check_bit("en_on_v", v_o, 1'b1);
        check("en_on_data", data_o, pk(4'd2, 1'b0, 3'd0, 8'h61, 64'h55));
        idle(1);
        yumi_i = 1'b1;
        idle(3);
        check_int("en_single_reply", got.size(), base + 1);
        check_got("en_reply", base, pk(4'd2, 1'b0, 3'd0, 8'h61, 64'h55));

        // Reset mid-stream discards buffered replies and clears scratch
        yumi_i = 1'b0;
        send(pk(4'd0, 1'b0, 3'd1, 8'h71, 64'h77));
        send(pk(4'd0, 1'b0, 3'd0, 8'h72, 64'h78));
        reset_n = 1'b0;
        #1;
        check_bit("rst_mid_v", v_o, 1'b0);
        check_bit("rst_mid_ready", ready_o, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        yumi_i  = 1'b1;
        base    = got.size();
        send(pk(4'd0, 1'b0, 3'd2, 8'h73, 64'd0));
        idle(3);
        check_int("rst_mid_discard", got.size(), base + 1);
        check_got("read_after_reset", base, pk(4'd2, 1'b0, 3'd2, 8'h73, 64'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
